// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : calc_engine
//  Purpose  : Evaluates "a op b" from a 4-bit symbol FIFO (two-digit operands,
//             + - * /) into an 8-bit sign/magnitude result.
//  Revision : 1.0  initial release
// ============================================================================
module calc_engine (
    input  logic       CLK_50M,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        N1   = 3'd1,
        OP   = 3'd2,
        N2   = 3'd3,
        CALN = 3'd4,
        FIN  = 3'd5
    } state_t;

    // Operator codes are the low two bits of symbols 0xA..0xD
    localparam logic [1:0] c_OP_ADD     = 2'b10;
    localparam logic [1:0] c_OP_SUB     = 2'b11;
    localparam logic [1:0] c_OP_MUL     = 2'b00;
    localparam logic [1:0] c_OP_DIV     = 2'b01;
    localparam logic [1:0] c_MAX_DIGITS = 2'd2;
    localparam logic [2:0] c_MUL_LAST   = 3'd6;

    state_t      r_state;
    logic        r_settle;
    logic [1:0]  r_cnt;
    logic [6:0]  r_a;
    logic [6:0]  r_b;
    logic [1:0]  r_op;
    logic [13:0] r_acc;
    logic [2:0]  r_iter;
    logic [6:0]  r_rem;
    logic [6:0]  r_quo;
    logic        r_res_sign;
    logic [6:0]  r_res_mag;
    logic [7:0]  r_result;
    logic        r_done;
    logic        r_err;

    logic        w_pop_cycle;
    logic        w_is_digit;
    logic        w_is_op;
    logic [6:0]  w_operand;
    logic [6:0]  w_accum_next;
    logic [7:0]  w_sum;
    logic [13:0] w_partial;
    logic [13:0] w_acc_next;

    // The pop strobe is gated directly by fifo_empty so it can never fire on an empty FIFO
    assign w_pop_cycle  = ((r_state == N1) || (r_state == N2)) && !r_settle;
    assign fifo_rd      = w_pop_cycle && !fifo_empty;

    assign w_is_digit   = (fifo_data <= 4'd9);
    assign w_is_op      = (fifo_data >= 4'hA) && (fifo_data <= 4'hD);
    assign w_operand    = (r_state == N2) ? r_b : r_a;
    assign w_accum_next = w_operand * 7'd10 + {3'b000, fifo_data};

    assign w_sum        = {1'b0, r_a} + {1'b0, r_b};
    assign w_partial    = r_b[r_iter] ? ({7'b0000000, r_a} << r_iter) : 14'd0;
    assign w_acc_next   = r_acc + w_partial;

    assign result = r_result;
    assign done   = r_done;
    assign err    = r_err;
    assign busy   = (r_state != IDLE);

    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_settle   <= 1'b0;
            r_cnt      <= 2'd0;
            r_a        <= 7'd0;
            r_b        <= 7'd0;
            r_op       <= 2'd0;
            r_acc      <= 14'd0;
            r_iter     <= 3'd0;
            r_rem      <= 7'd0;
            r_quo      <= 7'd0;
            r_res_sign <= 1'b0;
            r_res_mag  <= 7'd0;
            r_result   <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a        <= 7'd0;
                        r_b        <= 7'd0;
                        r_cnt      <= 2'd0;
                        r_err      <= 1'b0;
                        r_result   <= 8'h00;
                        r_res_sign <= 1'b0;
                        r_res_mag  <= 7'd0;
                        r_settle   <= 1'b0;
                        r_state    <= N1;
                    end
                end

                N1: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (fifo_empty) begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end else if (w_is_digit) begin
                        if (r_cnt == c_MAX_DIGITS) begin
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_a      <= w_accum_next;
                            r_cnt    <= r_cnt + 2'd1;
                            r_settle <= 1'b1;
                        end
                    end else if (w_is_op && (r_cnt != 2'd0)) begin
                        r_op    <= fifo_data[1:0];
                        r_state <= OP;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end
                end

                OP: begin
                    r_cnt   <= 2'd0;
                    r_state <= N2;
                end

                N2: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (fifo_empty) begin
                        if (r_cnt != 2'd0) begin
                            r_acc   <= 14'd0;
                            r_iter  <= 3'd0;
                            r_rem   <= r_a;
                            r_quo   <= 7'd0;
                            r_state <= CALN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end
                    end else if (w_is_digit && (r_cnt != c_MAX_DIGITS)) begin
                        r_b      <= w_accum_next;
                        r_cnt    <= r_cnt + 2'd1;
                        r_settle <= 1'b1;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end
                end

                CALN: begin
                    case (r_op)
                        c_OP_ADD: begin
                            r_res_sign <= 1'b0;
                            r_res_mag  <= w_sum[6:0];
                            if (w_sum > 8'd127) r_err <= 1'b1;
                            r_state    <= FIN;
                        end
                        c_OP_SUB: begin
                            if (r_b > r_a) begin
                                r_res_sign <= 1'b1;
                                r_res_mag  <= r_b - r_a;
                            end else begin
                                r_res_sign <= 1'b0;
                                r_res_mag  <= r_a - r_b;
                            end
                            r_state <= FIN;
                        end
                        c_OP_MUL: begin
                            r_acc <= w_acc_next;
                            if (r_iter == c_MUL_LAST) begin
                                r_res_sign <= 1'b0;
                                r_res_mag  <= w_acc_next[6:0];
                                if (w_acc_next > 14'd127) r_err <= 1'b1;
                                r_state    <= FIN;
                            end else begin
                                r_iter <= r_iter + 3'd1;
                            end
                        end
                        default: begin
                            // Divide: one trial subtraction per cycle until the remainder drops below b
                            if (r_b == 7'd0) begin
                                r_err   <= 1'b1;
                                r_state <= FIN;
                            end else if (r_rem >= r_b) begin
                                r_rem <= r_rem - r_b;
                                r_quo <= r_quo + 7'd1;
                            end else begin
                                r_res_sign <= 1'b0;
                                r_res_mag  <= r_quo;
                                r_state    <= FIN;
                            end
                        end
                    endcase
                end

                FIN: begin
                    r_result <= r_err ? 8'h00 : {r_res_sign, r_res_mag};
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_engine
//  Purpose  : Self-checking bench for calc_engine against an expression-level
//             reference model with a queue-based FWFT FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_engine;

    logic       CLK_50M = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] fifo_data  = 4'd0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       err;

    calc_engine dut (
        .CLK_50M    (CLK_50M),
        .reset      (reset),
        .start      (start),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #10 CLK_50M = ~CLK_50M;

    logic [3:0] q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_result = 8'h00;
    logic       exp_err    = 1'b0;
    logic [7:0] held_result = 8'h00;
    logic       held_err    = 1'b0;
    bit         hold_valid  = 1'b0;
    bit         eval_open   = 1'b0;
    int         done_seen   = 0;
    logic       prev_done   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() == 0) ? 4'd0 : q[0];
    endfunction

    // Expression-level reference: returns the result byte, error flag and symbols consumed
    function automatic void model(input logic [3:0] s[$], output logic [7:0] res,
                                  output logic e, output int used);
        int a, b, cnt, i, op, r;
        logic [3:0] sym;
        a = 0; b = 0; cnt = 0; i = 0; op = 0; r = 0;
        res = 8'h00; e = 1'b0; used = 0;
        while (1) begin
            if (i == s.size()) begin e = 1'b1; used = i; return; end
            sym = s[i]; i++;
            if (sym <= 4'd9) begin
                if (cnt == 2) begin e = 1'b1; used = i; return; end
                a = a * 10 + int'(sym); cnt++;
            end else if (sym <= 4'hD && cnt > 0) begin
                op = int'(sym);
                break;
            end else begin
                e = 1'b1; used = i; return;
            end
        end
        cnt = 0;
        while (1) begin
            if (i == s.size()) begin
                if (cnt == 0) begin e = 1'b1; used = i; return; end
                break;
            end
            sym = s[i]; i++;
            if (sym <= 4'd9 && cnt < 2) begin
                b = b * 10 + int'(sym); cnt++;
            end else begin
                e = 1'b1; used = i; return;
            end
        end
        used = i;
        case (op)
            10: r = a + b;
            11: r = a - b;
            12: r = a * b;
            default: begin
                if (b == 0) begin e = 1'b1; return; end
                r = a / b;
            end
        endcase
        if (r < 0)        res = {1'b1, 7'(-r)};
        else if (r > 127) e = 1'b1;
        else              res = 8'(r);
    endfunction

    // FWFT FIFO: pop on a sampled strobe, present the new head just after the edge
    always @(posedge CLK_50M) begin
        bit pop;
        pop = fifo_rd;
        #1;
        if (pop && q.size() > 0) void'(q.pop_front());
        refresh();
    end

    // Per-cycle compare against the model's expectations
    always @(negedge CLK_50M) begin
        if (fifo_rd) check("rd_while_empty", int'(fifo_empty), 0);
        if (!reset) begin
            check("reset_outputs", int'({result, busy, done, err, fifo_rd}), 0);
            hold_valid = 1'b0;
        end else begin
            if (busy) hold_valid = 1'b0;
            if (done) begin
                check("done_expected", int'(eval_open), 1);
                check("done_width", int'(prev_done), 0);
                check("result", int'(result), int'(exp_result));
                check("err", int'(err), int'(exp_err));
                eval_open   = 1'b0;
                done_seen++;
                held_result = exp_result;
                held_err    = exp_err;
                hold_valid  = 1'b1;
            end else if (hold_valid && !busy) begin
                check("result_hold", int'(result), int'(held_result));
                check("err_hold", int'(err), int'(held_err));
            end
        end
        prev_done = done;
    end

    task automatic run(input logic [3:0] syms[$], input int budget, input bit extra_start,
                       output int lat);
        logic [7:0] r;
        logic       e;
        int         used, base, t;
        @(posedge CLK_50M); #2;
        q = syms;
        refresh();
        model(syms, r, e, used);
        exp_result = r;
        exp_err    = e;
        base       = done_seen;
        eval_open  = 1'b1;
        start = 1'b1;
        @(posedge CLK_50M); #2;
        start = 1'b0;
        t = 0;
        while (done_seen == base && t < budget) begin
            start = extra_start && (t == 3);
            @(posedge CLK_50M); #2;
            t++;
        end
        start = 1'b0;
        lat = t;
        check("done_count", done_seen - base, 1);
        check("fifo_left", q.size(), syms.size() - used);
    endtask

    initial begin : watchdog
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [3:0] s[$];
        logic [7:0] mr;
        logic       me;
        int         mu, lat, na, nb, pick, base;

        repeat (3) @(posedge CLK_50M);
        #2 reset = 1'b1;
        repeat (2) @(posedge CLK_50M);

        // Model pinned against hand-computed values
        s = {4'd1, 4'd2, 4'hA, 4'd3, 4'd4}; model(s, mr, me, mu);
        check("model_add", int'(mr), 8'h2E);
        s = {4'd3, 4'hB, 4'd9};             model(s, mr, me, mu);
        check("model_sub", int'(mr), 8'h86);
        s = {4'd1, 4'd2, 4'd3, 4'hA, 4'd4}; model(s, mr, me, mu);
        check("model_3digit_used", mu, 3);

        s = {4'd1, 4'd2, 4'hA, 4'd3, 4'd4}; run(s, 200, 0, lat);
        check("lit_add_result", int'(result), 8'h2E);
        check("lit_add_err", int'(err), 0);
        check("lit_add_fifo_empty", int'(fifo_empty), 1);

        s = {4'd3, 4'hB, 4'd9};             run(s, 200, 0, lat);
        check("lit_sub_result", int'(result), 8'h86);

        s = {4'd1, 4'd2, 4'hC, 4'd1, 4'd1}; run(s, 200, 0, lat);
        check("lit_mul_ovf_err", int'(err), 1);
        check("lit_mul_ovf_result", int'(result), 8'h00);

        // Divide with a start pulse issued while busy
        s = {4'd9, 4'd9, 4'hD, 4'd7};       run(s, 300, 1, lat);
        check("lit_div_result", int'(result), 8'h0E);
        check("lit_div_err", int'(err), 0);

        s = {4'd5, 4'hD, 4'd0};             run(s, 200, 0, lat);
        check("lit_div0_err", int'(err), 1);

        s = {4'd1, 4'd2, 4'd3, 4'hA, 4'd4}; run(s, 200, 0, lat);
        check("lit_3digit_err", int'(err), 1);
        check("lit_3digit_left", q.size(), 2);

        s = {};                             run(s, 20, 0, lat);
        check("lit_empty_err", int'(err), 1);
        check("lit_empty_latency_ok", int'(lat <= 3), 1);

        // Reset in the third multiply cycle of "9*9"
        @(posedge CLK_50M); #2;
        q = {4'd9, 4'hC, 4'd9};
        refresh();
        base = done_seen;
        start = 1'b1;
        @(posedge CLK_50M); #2;
        start = 1'b0;
        repeat (9) @(posedge CLK_50M);
        #5 reset = 1'b0;
        #1 check("rst_immediate", int'({result, busy, done, err, fifo_rd}), 0);
        repeat (3) @(posedge CLK_50M);
        #2 reset = 1'b1;
        repeat (4) @(posedge CLK_50M);
        check("rst_no_done", done_seen - base, 0);
        s = {4'd9, 4'hC, 4'd9};             run(s, 200, 0, lat);
        check("lit_rerun_mul", int'(result), 8'h51);

        // Randomized expressions, including malformed ones
        for (int k = 0; k < 60; k++) begin
            s  = {};
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            repeat (na) s.push_back(4'($urandom_range(0, 9)));
            pick = $urandom_range(0, 9);
            s.push_back((pick < 8) ? 4'(10 + pick % 4) : 4'(14 + pick % 2));
            repeat (nb) s.push_back(4'($urandom_range(0, 9)));
            if ($urandom_range(0, 7) == 0) s.push_back(4'($urandom_range(0, 15)));
            run(s, 300, 0, lat);
        end

        repeat (3) @(posedge CLK_50M);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 The block SHALL expose port CLK_50M, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL expose port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL expose port start, input, 1 bit: one-cycle debounced calculate request.
REQ-004 The block SHALL expose port fifo_data, input, 4 bits: head symbol of the upstream symbol FIFO, first-word-fall-through, valid while fifo_empty=0.
REQ-005 The block SHALL expose port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-006 The block SHALL expose port fifo_rd, output, 1 bit: one-cycle pop strobe to the upstream FIFO.
REQ-007 The block SHALL expose port result, output, 8 bits: {sign, magnitude[6:0]}, sign=1 means negative.
REQ-008 The block SHALL expose port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL expose port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL expose port err, output, 1 bit: sticky error flag for the last evaluation.

Function
REQ-011 Symbol encoding SHALL be: 0x0-0x9 digit, 0xA add, 0xB subtract, 0xC multiply, 0xD divide, 0xE/0xF invalid.
REQ-012 The FSM SHALL have exactly the states IDLE, N1, OP, N2, CALN and FIN.
REQ-013 In IDLE, start=1 SHALL clear the operands, digit count, err and result, and go to N1; start in any other state SHALL be ignored.
REQ-014 Each consumed symbol SHALL take exactly 2 cycles: a pop cycle with fifo_rd=1 and fifo_data sampled, then a settle cycle with fifo_rd=0 and no sampling.
REQ-015 N1 with a digit d SHALL update a = a*10 + d and increment the digit count; a third digit SHALL set err and go to FIN.
REQ-016 N1 with an operator and count>=1 SHALL latch the operator and go to OP; OP is the settle cycle; it clears the digit count and goes to N2.
REQ-017 N1 with fifo_empty=1, an operator at count 0, or an invalid symbol SHALL set err and go to FIN.
REQ-018 N2 SHALL accumulate b as in REQ-015, including the 2-digit limit.
REQ-019 N2 with fifo_empty=1 and count>=1 SHALL go to CALN; fifo_empty=1 with count 0, any operator, or an invalid symbol SHALL set err and go to FIN.
REQ-020 CALN add SHALL take 1 cycle: a+b; a sum >127 SHALL set err.
REQ-021 CALN subtract SHALL take 1 cycle: if b>a, then sign=1 and magnitude=b-a; otherwise sign=0 and magnitude=a-b.
REQ-022 CALN multiply SHALL be a 7-iteration shift-add at 1 bit/cycle using a 14-bit accumulator; a final product >127 SHALL set err.
REQ-023 CALN divide SHALL use repeated subtraction at 1 subtraction/cycle, producing the truncated quotient; b=0 SHALL set err in the first CALN cycle without iterating.
REQ-024 FIN SHALL drive result (0x00 when err=1), pulse done for 1 cycle, and return to IDLE.
REQ-025 result and err SHALL hold until the next accepted start.
REQ-026 fifo_rd SHALL never assert while fifo_empty=1 or outside N1/N2 pop cycles.
REQ-027 On error, unconsumed symbols SHALL be left in the FIFO.
REQ-028 A zero result SHALL always have sign=0.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, with result=0x00, busy=0, done=0, err=0, fifo_rd=0, operands cleared.
REQ-030 Reset asserted mid-operation SHALL abandon the evaluation with no done pulse; the first accepted start after release SHALL begin cleanly.

Verification
REQ-031 FIFO "1,2,+,3,4", start -> 5 pops, then result=0x2E, err=0, done pulse 1 cycle; FIFO empty.
REQ-032 FIFO "3,-,9", start -> result=0x86 (sign 1, magnitude 6), err=0.
REQ-033 FIFO "1,2,*,1,1" -> err=1, result=0x00; FIFO "9,9,/,7" -> result=0x0E after the divide loop, err=0.
REQ-034 FIFO "5,/,0" -> err=1, result=0x00; FIFO "1,2,3,+,4" -> err=1 after the third digit, with "+,4" left in the FIFO.
REQ-035 start with the FIFO empty -> err=1 and done pulse within 3 cycles, with no fifo_rd; start while busy -> ignored, with the evaluation unaffected.
REQ-036 reset=0 in the 3rd cycle of CALN multiply on "9,*,9" -> all outputs 0, no done pulse; re-run after release -> result=0x51.
